// File: rtl/tx_pkg.sv
// Shared constants for the TX signal generator: default parameters, sine LUT,
// LFSR seed nibble/taps and FSM state encodings.
package tx_pkg;

    localparam int unsigned TX_SAMPLE_DIV_DEFAULT    = 128;
    localparam int unsigned TX_CHIPS_PER_SEQ_DEFAULT = 255;

    localparam logic [3:0] TX_SEED_NIBBLE = 4'hA;
    // Feedback taps b7, b5, b4, b3.
    localparam logic [7:0] TX_LFSR_TAPS   = 8'b1011_1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TX   = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic signed [15:0] sine_lut(input logic [2:0] idx);
        logic signed [15:0] v;
        case (idx)
            3'd0:    v = 16'sd0;
            3'd1:    v = 16'sd11585;
            3'd2:    v = 16'sd16383;
            3'd3:    v = 16'sd11585;
            3'd4:    v = 16'sd0;
            3'd5:    v = -16'sd11585;
            3'd6:    v = -16'sd16383;
            default: v = -16'sd11585;
        endcase
        return v;
    endfunction

    // The low nibble is constant and non-zero, so the LFSR can never lock up.
    function automatic logic [7:0] make_seed(input logic [3:0] seq_id);
        return {seq_id, TX_SEED_NIBBLE};
    endfunction

endpackage

// File: rtl/tx_prbs_lfsr.sv
// 8-bit Fibonacci PRBS generator; shifts right with the tap parity entering b7,
// and presents b0 of the current state as the chip.
module tx_prbs_lfsr
    import tx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic       chip
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Load wins over advance so a new transmission always starts from its seed.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            if (load) begin
                lfsr_d = seed;
            end else if (advance) begin
                lfsr_d = {^(lfsr_q & TX_LFSR_TAPS), lfsr_q[7:1]};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign chip = lfsr_q[0];

endmodule

// File: rtl/tx_signal_generator.sv
// BPSK-style PRBS sine-chip transmitter: IDLE -> TX -> DONE -> IDLE.
// Optional first-sample timestamp counter enabled by macro TX_TIMESTAMP_EN.
module tx_signal_generator
    import tx_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV    = TX_SAMPLE_DIV_DEFAULT,
    parameter int unsigned CHIPS_PER_SEQ = TX_CHIPS_PER_SEQ_DEFAULT
) (
    input  logic               ctx_clk,
    input  logic               rtx_rst,
    input  logic               etx_en,
    input  logic               istart,
    input  logic [3:0]         iseq_id,
    output logic signed [15:0] osample,
    output logic               osample_valid,
    output logic               obusy,
    output logic               odone,
    output logic [31:0]        otx_timestamp
);

    localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CHIP_W = $clog2(CHIPS_PER_SEQ + 1);

    logic [1:0]         state_q,    state_d;
    logic [DIV_W-1:0]   div_q,      div_d;
    logic [2:0]         sidx_q,     sidx_d;
    logic [CHIP_W-1:0]  chip_cnt_q, chip_cnt_d;
    logic signed [15:0] osample_q,  osample_d;
    logic               valid_q,    valid_d;
    logic               done_q,     done_d;

    logic               strobe;
    logic               lfsr_load;
    logic               lfsr_adv;
    logic               chip;
    logic [7:0]         seed;
    logic signed [15:0] lut_val;

    assign seed    = make_seed(iseq_id);
    assign lut_val = sine_lut(sidx_q);

    tx_prbs_lfsr u_lfsr (
        .clock   (ctx_clk),
        .reset   (rtx_rst),
        .enable  (etx_en),
        .load    (lfsr_load),
        .seed    (seed),
        .advance (lfsr_adv),
        .chip    (chip)
    );

    // chip_cnt_q reaching CHIPS_PER_SEQ means every sample has been emitted,
    // so TX leaves on the clock right after the final strobe.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        sidx_d     = sidx_q;
        chip_cnt_d = chip_cnt_q;
        osample_d  = osample_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        strobe     = 1'b0;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (istart) begin
                    state_d    = ST_TX;
                    div_d      = '0;
                    sidx_d     = '0;
                    chip_cnt_d = '0;
                    lfsr_load  = 1'b1;
                end
            end
            ST_TX: begin
                if (chip_cnt_q == CHIP_W'(CHIPS_PER_SEQ)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    strobe = (div_q == '0);
                    div_d  = (div_q == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_q + DIV_W'(1);
                    if (strobe) begin
                        valid_d   = 1'b1;
                        osample_d = chip ? lut_val : -lut_val;
                        sidx_d    = sidx_q + 3'd1;
                        if (sidx_q == 3'd7) begin
                            lfsr_adv   = 1'b1;
                            chip_cnt_d = chip_cnt_q + CHIP_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                osample_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With the enable low everything holds; only the one-clock pulses drop.
    always_ff @(posedge ctx_clk) begin
        if (rtx_rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            sidx_q     <= '0;
            chip_cnt_q <= '0;
            osample_q  <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else if (etx_en) begin
            state_q    <= state_d;
            div_q      <= div_d;
            sidx_q     <= sidx_d;
            chip_cnt_q <= chip_cnt_d;
            osample_q  <= osample_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end else begin
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end
    end

`ifdef TX_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;

    // The first strobe of a run is the only one with chip 0, sample 0.
    always_ff @(posedge ctx_clk) begin
        if (rtx_rst) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else if (etx_en) begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (strobe && (chip_cnt_q == '0) && (sidx_q == 3'd0)) begin
                ts_q <= ts_cnt_q;
            end
        end
    end

    assign otx_timestamp = ts_q;
`else
    assign otx_timestamp = '0;
`endif

    assign osample       = osample_q;
    assign osample_valid = valid_q;
    assign obusy         = (state_q != ST_IDLE);
    assign odone         = done_q;

endmodule

// File: tb/tb_tx_signal_generator.sv
// Bench for tx_signal_generator: random sequence ids and enable patterns
// checked against a chip/sample reference model built from the PRBS rules.
module tb_tx_signal_generator;

    localparam int SAMPLE_DIV    = 8;
    localparam int CHIPS_PER_SEQ = 150;
    localparam int NUM_SAMPLES   = CHIPS_PER_SEQ * 8;
    localparam int BUDGET        = 4 * SAMPLE_DIV + 8;

    logic               ctxClk = 1'b0;
    logic               rtxRst;
    logic               etxEn;
    logic               istart;
    logic [3:0]         iseqId;
    logic signed [15:0] osample;
    logic               osampleValid;
    logic               obusy;
    logic               odone;
    logic [31:0]        otxTimestamp;

    int          total = 0;
    int          bad   = 0;
    int          enTicks = 0;
    logic [31:0] tsModel = '0;
    logic [31:0] accTs;

    tx_signal_generator #(
        .SAMPLE_DIV    (SAMPLE_DIV),
        .CHIPS_PER_SEQ (CHIPS_PER_SEQ)
    ) dut (
        .ctx_clk       (ctxClk),
        .rtx_rst       (rtxRst),
        .etx_en        (etxEn),
        .istart        (istart),
        .iseq_id       (iseqId),
        .osample       (osample),
        .osample_valid (osampleValid),
        .obusy         (obusy),
        .odone         (odone),
        .otx_timestamp (otxTimestamp)
    );

    always #5 ctxClk = ~ctxClk;

    // Sample n of a transmission: chip n/8 of the PRBS, phase n%8 of the sine.
    function automatic logic signed [15:0] modelSample(input int id, input int n);
        int lut [8] = '{0, 11585, 16383, 11585, 0, -11585, -16383, -11585};
        int s;
        int fb;
        s = id * 16 + 10;
        for (int c = 0; c < n / 8; c++) begin
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s  = ((s >> 1) | (fb << 7)) & 255;
        end
        return (s & 1) ? 16'(lut[n % 8]) : 16'(-lut[n % 8]);
    endfunction

    function automatic logic [31:0] expTimestamp(input logic [31:0] v);
`ifdef TX_TIMESTAMP_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic tick();
        @(posedge ctxClk);
        if (rtxRst) begin
            tsModel = '0;
        end else if (etxEn) begin
            tsModel = tsModel + 32'd1;
            enTicks++;
        end
        #1;
    endtask

    task automatic applyReset();
        rtxRst = 1'b1;
        etxEn  = 1'b1;
        istart = 1'($urandom_range(0, 1));
        iseqId = 4'($urandom);
        tick();
        tick();
        rtxRst = 1'b0;
        istart = 1'b0;
    endtask

    task automatic startRun(input logic [3:0] id);
        iseqId = id;
        istart = 1'b1;
        tick();
        istart = 1'b0;
        iseqId = 4'($urandom);
        accTs  = tsModel;
    endtask

    task automatic waitStrobe(output bit ok, output int clkGap);
        ok     = 1'b0;
        clkGap = 0;
        while (!ok && clkGap < BUDGET) begin
            tick();
            clkGap++;
            if (osampleValid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        applyReset();
        total++; if (osample !== 16'sd0) begin bad++; $display("[TB] FAIL reset_osample: got %0d want 0", osample); end
        total++; if (osampleValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", osampleValid); end
        total++; if (obusy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", obusy); end
        total++; if (odone !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", odone); end
        total++; if (otxTimestamp !== 32'd0) begin bad++; $display("[TB] FAIL reset_ts: got %0d want 0", otxTimestamp); end
    endtask

    task automatic test_start_needs_enable();
        applyReset();
        etxEn  = 1'b0;
        istart = 1'b1;
        iseqId = 4'd3;
        tick();
        tick();
        istart = 1'b0;
        etxEn  = 1'b1;
        tick();
        total++; if (obusy !== 1'b0) begin bad++; $display("[TB] FAIL start_disabled_busy: got %b want 0", obusy); end
        total++; if (osampleValid !== 1'b0) begin bad++; $display("[TB] FAIL start_disabled_valid: got %b want 0", osampleValid); end
    endtask

    task automatic test_first_samples();
        int  expFirst [8] = '{0, -11585, -16383, -11585, 0, 11585, 16383, 11585};
        bit  ok;
        int  gap;
        applyReset();
        startRun(4'd0);
        total++; if (obusy !== 1'b1) begin bad++; $display("[TB] FAIL first_busy: got %b want 1", obusy); end
        total++; if (osampleValid !== 1'b0) begin bad++; $display("[TB] FAIL first_early_valid: got %b want 0", osampleValid); end
        for (int i = 0; i < 8; i++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL first_timeout: sample %0d not seen within %0d clocks", i, BUDGET); return; end
            total++; if (gap !== ((i == 0) ? 1 : SAMPLE_DIV)) begin bad++; $display("[TB] FAIL first_gap[%0d]: got %0d want %0d", i, gap, (i == 0) ? 1 : SAMPLE_DIV); end
            total++; if (osample !== 16'(expFirst[i])) begin bad++; $display("[TB] FAIL first_sample[%0d]: got %0d want %0d", i, osample, expFirst[i]); end
        end
        total++; if (otxTimestamp !== expTimestamp(accTs)) begin bad++; $display("[TB] FAIL first_ts: got %0d want %0d", otxTimestamp, expTimestamp(accTs)); end
    endtask

    task automatic test_full_run();
        bit          ok;
        int          gap;
        int          extra;
        logic [3:0]  id;
        logic [3:0]  id2;
        applyReset();
        id = 4'($urandom);
        startRun(id);
        for (int n = 0; n < NUM_SAMPLES; n++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL full_timeout: sample %0d not seen", n); return; end
            total++; if (gap !== ((n == 0) ? 1 : SAMPLE_DIV)) begin bad++; $display("[TB] FAIL full_gap[%0d]: got %0d want %0d", n, gap, (n == 0) ? 1 : SAMPLE_DIV); end
            total++; if (osample !== modelSample(id, n)) begin bad++; $display("[TB] FAIL full_sample[%0d]: got %0d want %0d", n, osample, modelSample(id, n)); end
        end
        tick();
        total++; if (odone !== 1'b1) begin bad++; $display("[TB] FAIL full_done_pulse: got %b want 1", odone); end
        total++; if (obusy !== 1'b1) begin bad++; $display("[TB] FAIL full_busy_in_done: got %b want 1", obusy); end
        total++; if (osampleValid !== 1'b0) begin bad++; $display("[TB] FAIL full_valid_in_done: got %b want 0", osampleValid); end
        tick();
        total++; if (odone !== 1'b0) begin bad++; $display("[TB] FAIL full_done_width: got %b want 0", odone); end
        total++; if (obusy !== 1'b0) begin bad++; $display("[TB] FAIL full_idle_busy: got %b want 0", obusy); end
        total++; if (osample !== 16'sd0) begin bad++; $display("[TB] FAIL full_idle_sample: got %0d want 0", osample); end
        extra = 0;
        repeat (2 * SAMPLE_DIV) begin
            tick();
            if (osampleValid) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("[TB] FAIL full_extra_strobes: got %0d want 0", extra); end
        id2 = 4'($urandom);
        startRun(id2);
        for (int n = 0; n < 8; n++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL b2b_timeout: sample %0d not seen", n); return; end
            total++; if (osample !== modelSample(id2, n)) begin bad++; $display("[TB] FAIL b2b_sample[%0d]: got %0d want %0d", n, osample, modelSample(id2, n)); end
        end
        total++; if (otxTimestamp !== expTimestamp(accTs)) begin bad++; $display("[TB] FAIL b2b_ts: got %0d want %0d", otxTimestamp, expTimestamp(accTs)); end
    endtask

    task automatic test_ignore_start();
        bit ok;
        int gap;
        int wantGap;
        applyReset();
        startRun(4'd0);
        wantGap = 1;
        for (int n = 0; n < 40; n++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL ignore_timeout: sample %0d not seen", n); return; end
            total++; if (gap !== wantGap) begin bad++; $display("[TB] FAIL ignore_gap[%0d]: got %0d want %0d", n, gap, wantGap); end
            total++; if (osample !== modelSample(0, n)) begin bad++; $display("[TB] FAIL ignore_sample[%0d]: got %0d want %0d", n, osample, modelSample(0, n)); end
            wantGap = SAMPLE_DIV;
            if (n == 19) begin
                iseqId = 4'd5;
                istart = 1'b1;
                tick();
                istart = 1'b0;
                wantGap = SAMPLE_DIV - 1;
                total++; if (obusy !== 1'b1) begin bad++; $display("[TB] FAIL ignore_busy: got %b want 1", obusy); end
            end
        end
    endtask

    task automatic test_enable_freeze();
        bit                 ok;
        int                 gap;
        int                 strobes;
        int                 changed;
        logic signed [15:0] held;
        logic [3:0]         id;
        applyReset();
        id = 4'($urandom);
        startRun(id);
        for (int n = 0; n < 32; n++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL freeze_timeout: sample %0d not seen", n); return; end
            if (n > 0) begin
                total++;
                if (gap !== ((n == 20) ? SAMPLE_DIV - 3 : SAMPLE_DIV)) begin
                    bad++; $display("[TB] FAIL freeze_gap[%0d]: got %0d want %0d", n, gap, (n == 20) ? SAMPLE_DIV - 3 : SAMPLE_DIV);
                end
            end
            total++; if (osample !== modelSample(id, n)) begin bad++; $display("[TB] FAIL freeze_sample[%0d]: got %0d want %0d", n, osample, modelSample(id, n)); end
            if (n == 19) begin
                held = osample;
                repeat (3) tick();
                etxEn   = 1'b0;
                strobes = 0;
                changed = 0;
                repeat (300) begin
                    tick();
                    if (osampleValid) strobes++;
                    if (osample !== held) changed++;
                end
                etxEn = 1'b1;
                total++; if (strobes !== 0) begin bad++; $display("[TB] FAIL freeze_strobes: got %0d want 0", strobes); end
                total++; if (changed !== 0) begin bad++; $display("[TB] FAIL freeze_hold: %0d changed clocks want 0", changed); end
                total++; if (obusy !== 1'b1) begin bad++; $display("[TB] FAIL freeze_busy: got %b want 1", obusy); end
            end
        end
    endtask

    task automatic test_random_enable();
        bit         got;
        int         c;
        int         e0;
        logic [3:0] id;
        applyReset();
        id = 4'($urandom);
        startRun(id);
        for (int n = 0; n < 48; n++) begin
            e0  = enTicks;
            c   = 0;
            got = 1'b0;
            while (!got && c < 4 * BUDGET) begin
                etxEn = ($urandom_range(0, 3) != 0);
                tick();
                c++;
                if (osampleValid) got = 1'b1;
            end
            etxEn = 1'b1;
            total++;
            if (!got) begin bad++; $display("[TB] FAIL rnd_timeout: sample %0d not seen", n); return; end
            total++; if ((enTicks - e0) !== ((n == 0) ? 1 : SAMPLE_DIV)) begin bad++; $display("[TB] FAIL rnd_en_gap[%0d]: got %0d want %0d", n, enTicks - e0, (n == 0) ? 1 : SAMPLE_DIV); end
            total++; if (osample !== modelSample(id, n)) begin bad++; $display("[TB] FAIL rnd_sample[%0d]: got %0d want %0d", n, osample, modelSample(id, n)); end
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        int         gap;
        int         extra;
        logic [3:0] id;
        applyReset();
        id = 4'($urandom);
        startRun(id);
        for (int n = 0; n <= 1000; n++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL rstmid_timeout: sample %0d not seen", n); return; end
            total++; if (osample !== modelSample(id, n)) begin bad++; $display("[TB] FAIL rstmid_sample[%0d]: got %0d want %0d", n, osample, modelSample(id, n)); end
        end
        rtxRst = 1'b1;
        istart = 1'b1;
        tick();
        rtxRst = 1'b0;
        istart = 1'b0;
        total++; if (obusy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b want 0", obusy); end
        total++; if (osample !== 16'sd0) begin bad++; $display("[TB] FAIL rstmid_sample: got %0d want 0", osample); end
        total++; if (osampleValid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %b want 0", osampleValid); end
        total++; if (otxTimestamp !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_ts: got %0d want 0", otxTimestamp); end
        extra = 0;
        repeat (2 * SAMPLE_DIV) begin
            tick();
            if (osampleValid || obusy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("[TB] FAIL rstmid_idle_activity: got %0d want 0", extra); end
        id = 4'($urandom);
        startRun(id);
        for (int n = 0; n < 16; n++) begin
            waitStrobe(ok, gap);
            total++;
            if (!ok) begin bad++; $display("[TB] FAIL restart_timeout: sample %0d not seen", n); return; end
            total++; if (gap !== ((n == 0) ? 1 : SAMPLE_DIV)) begin bad++; $display("[TB] FAIL restart_gap[%0d]: got %0d want %0d", n, gap, (n == 0) ? 1 : SAMPLE_DIV); end
            total++; if (osample !== modelSample(id, n)) begin bad++; $display("[TB] FAIL restart_sample[%0d]: got %0d want %0d", n, osample, modelSample(id, n)); end
        end
    endtask

    task automatic test_timestamp();
        bit          ok;
        int          gap;
        logic [31:0] want;
`ifdef TX_TIMESTAMP_EN
        want = 32'd1001;
`else
        want = 32'd0;
`endif
        applyReset();
        etxEn = 1'b1;
        repeat (1000) tick();
        startRun(4'($urandom));
        waitStrobe(ok, gap);
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL ts_timeout: first sample not seen"); return; end
        total++; if (otxTimestamp !== want) begin bad++; $display("[TB] FAIL ts_value: got %0d want %0d", otxTimestamp, want); end
    endtask

    initial begin
        rtxRst = 1'b1;
        etxEn  = 1'b0;
        istart = 1'b0;
        iseqId = 4'd0;
        test_reset();
        test_start_needs_enable();
        test_first_samples();
        test_full_run();
        test_ignore_start();
        test_enable_freeze();
        test_random_enable();
        test_reset_mid();
        test_timestamp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
